// File: rtl/lsu_mem_stage.sv
// Memory-access stage: runs loads/stores over a req/gnt/rvalid bus, aligns load data,
// and issues one registered writeback result per accepted op.
module lsu_mem_stage #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_wdata,
    input  logic        ex_load,
    input  logic        ex_store,
    input  logic [2:0]  ex_funct3,
    input  logic [4:0]  ex_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [1:0]  wb_exc
);

    localparam int unsigned CntW = $clog2(TIMEOUT);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            op_load_q, op_load_d;
    logic [2:0]      op_funct3_q, op_funct3_d;
    logic [1:0]      op_off_q, op_off_d;
    logic [4:0]      op_rd_q, op_rd_d;
    logic            mem_we_q, mem_we_d;
    logic [31:0]     mem_addr_q, mem_addr_d;
    logic [31:0]     mem_wdata_q, mem_wdata_d;
    logic [3:0]      mem_wstrb_q, mem_wstrb_d;
    logic            wb_valid_q, wb_valid_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [31:0]     wb_data_q, wb_data_d;
    logic [1:0]      wb_exc_q, wb_exc_d;

    logic        is_half, is_word, misaligned;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    // funct3[1:0]: 00 byte, 01 half, 1x word
    always_comb begin
        is_half    = (ex_funct3[1:0] == 2'b01);
        is_word    = ex_funct3[1];
        misaligned = (is_half & ex_result[0]) | (is_word & (|ex_result[1:0]));
        if (is_word) begin
            st_wdata = ex_wdata;
            st_wstrb = 4'b1111;
        end else if (is_half) begin
            st_wdata = {2{ex_wdata[15:0]}};
            st_wstrb = ex_result[1] ? 4'b1100 : 4'b0011;
        end else begin
            st_wdata = {4{ex_wdata[7:0]}};
            st_wstrb = 4'b0001 << ex_result[1:0];
        end
    end

    always_comb begin
        case (op_off_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = op_off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (op_funct3_q)
            3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
            3'd4:    ld_data = {24'd0, ld_byte};
            3'd5:    ld_data = {16'd0, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_load_d   = op_load_q;
        op_funct3_d = op_funct3_q;
        op_off_d    = op_off_q;
        op_rd_d     = op_rd_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        wb_valid_d  = 1'b0;
        wb_rd_d     = 5'd0;
        wb_data_d   = 32'd0;
        wb_exc_d    = 2'd0;
        unique case (state_q)
            StIdle: begin
                if (ex_valid) begin
                    if (!(ex_load || ex_store)) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = ex_rd;
                        wb_data_d  = ex_result;
                    end else if (misaligned) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = ex_result;
                        wb_exc_d   = 2'd1;
                    end else begin
                        op_load_d   = ex_load;
                        op_funct3_d = ex_funct3;
                        op_off_d    = ex_result[1:0];
                        op_rd_d     = ex_rd;
                        mem_we_d    = ex_store;
                        mem_addr_d  = {ex_result[31:2], 2'b00};
                        mem_wdata_d = st_wdata;
                        mem_wstrb_d = st_wstrb;
                        state_d     = StReq;
                    end
                end
            end
            StReq: begin
                if (mem_gnt) begin
                    cnt_d = '0;
                    // Response in the grant cycle completes the op directly.
                    if (mem_rvalid) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = op_load_q ? op_rd_q : 5'd0;
                        wb_data_d  = op_load_q ? ld_data : 32'd0;
                        state_d    = StIdle;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (mem_rvalid) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = op_load_q ? op_rd_q : 5'd0;
                    wb_data_d  = op_load_q ? ld_data : 32'd0;
                    state_d    = StIdle;
                end else if (cnt_q == CntLast) begin
                    wb_valid_d = 1'b1;
                    wb_exc_d   = 2'd2;
                    state_d    = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            op_load_q   <= 1'b0;
            op_funct3_q <= 3'd0;
            op_off_q    <= 2'd0;
            op_rd_q     <= 5'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_wstrb_q <= 4'd0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= 32'd0;
            wb_exc_q    <= 2'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_load_q   <= op_load_d;
            op_funct3_q <= op_funct3_d;
            op_off_q    <= op_off_d;
            op_rd_q     <= op_rd_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            wb_exc_q    <= wb_exc_d;
        end
    end

    assign ex_ready  = (state_q == StIdle);
    assign mem_req   = (state_q == StReq);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign wb_exc    = wb_exc_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: directed cases plus random ops against an arithmetic reference,
// with the bench acting as the memory bus.
module tb_lsu_mem_stage;

    localparam int unsigned TO = 8;
    localparam int NEVER = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, ex_ready, ex_load, ex_store;
    logic [31:0] ex_result, ex_wdata;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [1:0]  wb_exc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lsu_mem_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_result(ex_result), .ex_wdata(ex_wdata),
        .ex_load(ex_load), .ex_store(ex_store), .ex_funct3(ex_funct3), .ex_rd(ex_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_exc(wb_exc)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] d);
        int unsigned sh = 8 * (a % 4);
        logic [31:0] b = (d >> sh) & 32'hFF;
        logic [31:0] h = (d >> sh) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return d;
        endcase
    endfunction

    function automatic bit is_misaligned(input logic [2:0] f3, input logic [31:0] a);
        if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2) != 0) return 1'b1;
        if (f3 == 3'd2 && (a % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Starts and ends on a negedge; rv = WAIT cycle carrying rvalid (0: with gnt, >6: none).
    task automatic do_op(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd, input int gd,
                         input int rv, input logic [31:0] rdat);
        logic [31:0] e_data, e_wdata;
        logic [4:0]  e_rd;
        logic [1:0]  e_exc;
        logic [3:0]  e_strb;
        bit          chk_data = 1'b1;
        int          n;
        check_eq("ex_ready_idle", 32'(ex_ready), 1);
        ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_funct3 = f3;
        ex_result = a; ex_wdata = wd; ex_rd = rd;
        @(posedge clk); @(negedge clk);
        ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_result = $urandom;
        if (!(ld || st)) begin
            e_data = a; e_rd = rd; e_exc = 2'd0;
        end else if (is_misaligned(f3, a)) begin
            check_eq("mis_no_req", 32'(mem_req), 0);
            e_data = a; e_rd = 5'd0; e_exc = 2'd1;
        end else begin
            if (f3 == 3'd2) begin
                e_strb = 4'hF; e_wdata = wd;
            end else if (f3 == 3'd1) begin
                e_strb = (a % 4 >= 2) ? 4'hC : 4'h3; e_wdata = (wd & 32'hFFFF) * 32'h0001_0001;
            end else begin
                e_strb = 4'(1 << (a % 4)); e_wdata = (wd & 32'hFF) * 32'h0101_0101;
            end
            for (int i = 0; i <= gd; i++) begin
                check_eq("req_held", 32'(mem_req), 1);
                check_eq("req_we", 32'(mem_we), 32'(st));
                check_eq("req_addr", mem_addr, a - (a % 4));
                check_eq("req_wstrb", 32'(mem_wstrb), 32'(ld ? mem_wstrb : e_strb));
                if (st) check_eq("req_wdata", mem_wdata, e_wdata);
                check_eq("req_ex_ready", 32'(ex_ready), 0);
                check_eq("req_no_wb", 32'(wb_valid), 0);
                if (i == gd) begin
                    mem_gnt = 1'b1; mem_rvalid = (rv == 0); mem_rdata = rdat;
                end else begin
                    mem_rvalid = 1'($urandom % 2); mem_rdata = $urandom;
                end
                @(posedge clk); @(negedge clk);
                mem_gnt = 1'b0; mem_rvalid = 1'b0;
            end
            if (rv != 0) begin
                n = (rv <= 6) ? rv : TO;
                for (int j = 1; j <= n; j++) begin
                    check_eq("wait_no_req", 32'(mem_req), 0);
                    check_eq("wait_no_wb", 32'(wb_valid), 0);
                    check_eq("wait_ex_ready", 32'(ex_ready), 0);
                    if (j == rv) begin
                        mem_rvalid = 1'b1; mem_rdata = rdat;
                    end
                    @(posedge clk); @(negedge clk);
                    mem_rvalid = 1'b0;
                end
            end
            if (rv > 6) begin
                e_rd = 5'd0; e_exc = 2'd2; chk_data = 1'b0;
            end else begin
                e_exc = 2'd0;
                e_rd = ld ? rd : 5'd0;
                e_data = ld ? load_model(f3, a, rdat) : 32'd0;
            end
        end
        check_eq("wb_valid", 32'(wb_valid), 1);
        check_eq("wb_rd", 32'(wb_rd), 32'(e_rd));
        check_eq("wb_exc", 32'(wb_exc), 32'(e_exc));
        if (chk_data) check_eq("wb_data", wb_data, e_data);
    endtask

    task automatic idle_rvalid();
        mem_rvalid = 1'b1; mem_rdata = $urandom;
        @(posedge clk); @(negedge clk);
        mem_rvalid = 1'b0;
        check_eq("idle_rvalid_ignored", 32'(wb_valid), 0);
        check_eq("idle_rvalid_ready", 32'(ex_ready), 1);
    endtask

    initial begin
        logic [2:0] f3;
        int kind, rv;
        reset = 1'b1; ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_result = '0;
        ex_wdata = '0; ex_funct3 = '0; ex_rd = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ex_ready", 32'(ex_ready), 1);
        check_eq("rst_mem_req", 32'(mem_req), 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_wstrb", 32'(mem_wstrb), 0);
        check_eq("rst_wb_valid", 32'(wb_valid), 0);
        check_eq("rst_wb_data", wb_data, 0);
        reset = 1'b0;

        do_op(0, 0, 3'd0, 32'h1234_5678, 32'd0, 5'd7, 0, 0, 32'd0);
        do_op(1, 0, 3'd0, 32'h0000_0103, 32'd0, 5'd3, 0, 0, 32'h80AA_BBCC);
        do_op(1, 0, 3'd4, 32'h0000_0103, 32'd0, 5'd4, 0, 0, 32'h80AA_BBCC);
        do_op(0, 1, 3'd1, 32'h0000_0102, 32'h0000_BEEF, 5'd9, 3, 2, 32'd0);
        do_op(1, 0, 3'd2, 32'h0000_0201, 32'd0, 5'd5, 0, 0, 32'd0);
        do_op(1, 0, 3'd2, 32'h0000_0204, 32'd0, 5'd5, 1, 1, 32'hCAFE_F00D);
        do_op(1, 0, 3'd2, 32'h0000_0200, 32'd0, 5'd6, 0, NEVER, 32'd0);
        idle_rvalid();

        // Reset while a granted load sits in WAIT.
        ex_valid = 1'b1; ex_load = 1'b1; ex_funct3 = 3'd2; ex_result = 32'h300; ex_rd = 5'd8;
        @(posedge clk); @(negedge clk);
        ex_valid = 1'b0; ex_load = 1'b0; mem_gnt = 1'b1;
        @(posedge clk); @(negedge clk);
        mem_gnt = 1'b0;
        check_eq("pre_rst_in_wait", 32'(ex_ready), 0);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        check_eq("midrst_ex_ready", 32'(ex_ready), 1);
        check_eq("midrst_mem_req", 32'(mem_req), 0);
        check_eq("midrst_wb_valid", 32'(wb_valid), 0);
        idle_rvalid();

        for (int k = 0; k < 150; k++) begin
            kind = int'($urandom_range(0, 2));
            if (kind == 1) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0;
                    1: f3 = 3'd1;
                    2: f3 = 3'd2;
                    3: f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
            end else begin
                f3 = 3'($urandom_range(0, 2));
            end
            rv = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 6));
            do_op(kind == 1, kind == 2, f3, $urandom, $urandom, 5'($urandom),
                  int'($urandom_range(0, 3)), rv, $urandom);
            if ($urandom_range(0, 7) == 0) idle_rvalid();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
